// File: rtl/dcache_way_array.sv
// N-way set-associative D-cache storage: tag/data RAMs, valid/dirty/PLRU flops,
// a one-cycle read-first lookup with hit and victim selection, and a set-walking clear sweep.
module dcache_way_array #(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 20,
    parameter int OFF_W   = 2,
    localparam int SETS   = 2 ** INDEX_W,
    localparam int LINE_W = 32 * (2 ** OFF_W),
    localparam int BYTES  = 4 * (2 ** OFF_W),
    localparam int WW     = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int PW     = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic               clk,
    input  logic               resetn,
    output logic               ready,
    input  logic               rd_en,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               rsp_valid,
    output logic               hit,
    output logic [WW-1:0]      hit_way,
    output logic [LINE_W-1:0]  hit_line,
    output logic [WW-1:0]      vic_way,
    output logic [TAG_W-1:0]   vic_tag,
    output logic [LINE_W-1:0]  vic_line,
    output logic               vic_valid,
    output logic               vic_dirty,
    input  logic               wr_en,
    input  logic [WW-1:0]      wr_way,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [LINE_W-1:0]  wr_line,
    input  logic [BYTES-1:0]   wr_strb,
    input  logic               wr_tag_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_dv_en,
    input  logic               wr_valid,
    input  logic               wr_dirty,
    input  logic               inv_req,
    output logic               inv_done
);

    typedef enum logic [1:0] {INIT, IDLE, CLR} state_t;

    state_t             state;
    logic [INDEX_W-1:0] clr_ptr;

    logic [LINE_W-1:0] data_mem [WAYS][SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];
    logic [PW-1:0]     plru_q   [SETS];

    logic               rsp_valid_q;
    logic [INDEX_W-1:0] rd_index_q;
    logic [TAG_W-1:0]   rd_tag_q;
    logic [WAYS-1:0]    rd_valid_q;
    logic [WAYS-1:0]    rd_dirty_q;
    logic [PW-1:0]      rd_plru_q;
    logic [TAG_W-1:0]   rd_tags_q [WAYS];
    logic [LINE_W-1:0]  rd_line_q [WAYS];

    logic          rd_acc, wr_acc, dv_acc, hit_upd;
    logic          hit_c;
    logic [WW-1:0] hit_way_c, vic_way_c;
    logic [PW-1:0] refill_base;

    // PLRU bits point toward the victim; touching a way points them away from it.
    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [WW-1:0] w);
        logic [2:0] t;
        logic [1:0] wx;
        t  = 3'(p);
        wx = 2'(w);
        if (WAYS == 2) begin
            t[0] = ~wx[0];
        end else if (WAYS == 4) begin
            t[0] = ~wx[1];
            if (!wx[1]) t[1] = ~wx[0];
            else        t[2] = ~wx[0];
        end
        return t[PW-1:0];
    endfunction

    function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] p);
        logic [2:0] t;
        logic [1:0] v;
        t = 3'(p);
        v = 2'd0;
        if (WAYS == 2)      v = {1'b0, t[0]};
        else if (WAYS == 4) v = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
        return v[WW-1:0];
    endfunction

    assign rd_acc  = resetn & ready & rd_en;
    assign wr_acc  = resetn & ready & wr_en;
    assign dv_acc  = resetn & ready & wr_dv_en;
    assign hit_upd = resetn & rsp_valid_q & hit_c;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= INIT;
            clr_ptr  <= '0;
            ready    <= 1'b0;
            inv_done <= 1'b0;
        end else begin
            inv_done <= 1'b0;
            case (state)
                INIT, CLR: begin
                    clr_ptr <= clr_ptr + INDEX_W'(1);
                    if (clr_ptr == INDEX_W'(SETS - 1)) begin
                        state    <= IDLE;
                        ready    <= 1'b1;
                        inv_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (inv_req) begin
                        state   <= CLR;
                        clr_ptr <= '0;
                        ready   <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (wr_acc && wr_way == WW'(w)) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wr_strb[b]) data_mem[w][wr_index][b*8 +: 8] <= wr_line[b*8 +: 8];
                end
                if (wr_tag_en) tag_mem[w][wr_index] <= wr_tag;
            end
        end
    end

    // Later assignments win: hit touch, then refill touch, then the sweep clear.
    always_ff @(posedge clk) begin
        if (dv_acc) begin
            valid_q[wr_index][wr_way] <= wr_valid;
            dirty_q[wr_index][wr_way] <= wr_dirty;
        end
        if (hit_upd) plru_q[rd_index_q] <= plru_touch(plru_q[rd_index_q], hit_way_c);
        if (wr_acc && wr_tag_en) plru_q[wr_index] <= plru_touch(refill_base, wr_way);
        if (resetn && state != IDLE) begin
            valid_q[clr_ptr] <= '0;
            dirty_q[clr_ptr] <= '0;
            plru_q[clr_ptr]  <= '0;
        end
    end

    assign refill_base = (hit_upd && rd_index_q == wr_index) ?
                         plru_touch(plru_q[wr_index], hit_way_c) : plru_q[wr_index];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_valid_q <= 1'b0;
            rd_index_q  <= '0;
            rd_tag_q    <= '0;
            rd_valid_q  <= '0;
            rd_dirty_q  <= '0;
            rd_plru_q   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                rd_tags_q[w] <= '0;
                rd_line_q[w] <= '0;
            end
        end else begin
            rsp_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_index_q <= rd_index;
                rd_tag_q   <= rd_tag;
                rd_valid_q <= valid_q[rd_index];
                rd_dirty_q <= dirty_q[rd_index];
                rd_plru_q  <= plru_q[rd_index];
                for (int w = 0; w < WAYS; w++) begin
                    rd_tags_q[w] <= tag_mem[w][rd_index];
                    rd_line_q[w] <= data_mem[w][rd_index];
                end
            end
        end
    end

    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        vic_way_c = plru_victim(rd_plru_q);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_valid_q[w] && rd_tags_q[w] == rd_tag_q) begin
                hit_c     = 1'b1;
                hit_way_c = WW'(w);
            end
            if (!rd_valid_q[w]) vic_way_c = WW'(w);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign hit       = rsp_valid_q & hit_c;
    assign hit_way   = hit_way_c;
    assign hit_line  = rd_line_q[hit_way_c];
    assign vic_way   = vic_way_c;
    assign vic_tag   = rd_tags_q[vic_way_c];
    assign vic_line  = rd_line_q[vic_way_c];
    assign vic_valid = rd_valid_q[vic_way_c];
    assign vic_dirty = rd_dirty_q[vic_way_c];

endmodule

// File: tb/tb_dcache_way_array.sv
// Directed bench for dcache_way_array: a set/way model predicts every lookup response,
// plus literal checks on reset, refill, byte stores, read-first, PLRU and invalidate.
module tb_dcache_way_array;
    localparam int WAYS = 2, INDEX_W = 7, TAG_W = 20, OFF_W = 2;
    localparam int LINE_W = 128, BYTES = 16, SETS = 128;

    logic               clk = 1'b0;
    logic               resetn;
    logic               ready;
    logic               rd_en;
    logic [INDEX_W-1:0] rd_index;
    logic [TAG_W-1:0]   rd_tag;
    logic               rsp_valid;
    logic               hit;
    logic [0:0]         hit_way;
    logic [LINE_W-1:0]  hit_line;
    logic [0:0]         vic_way;
    logic [TAG_W-1:0]   vic_tag;
    logic [LINE_W-1:0]  vic_line;
    logic               vic_valid;
    logic               vic_dirty;
    logic               wr_en;
    logic [0:0]         wr_way;
    logic [INDEX_W-1:0] wr_index;
    logic [LINE_W-1:0]  wr_line;
    logic [BYTES-1:0]   wr_strb;
    logic               wr_tag_en;
    logic [TAG_W-1:0]   wr_tag;
    logic               wr_dv_en;
    logic               wr_valid;
    logic               wr_dirty;
    logic               inv_req;
    logic               inv_done;

    always #5 clk = ~clk;

    dcache_way_array #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .resetn(resetn), .ready(ready),
        .rd_en(rd_en), .rd_index(rd_index), .rd_tag(rd_tag),
        .rsp_valid(rsp_valid), .hit(hit), .hit_way(hit_way), .hit_line(hit_line),
        .vic_way(vic_way), .vic_tag(vic_tag), .vic_line(vic_line),
        .vic_valid(vic_valid), .vic_dirty(vic_dirty),
        .wr_en(wr_en), .wr_way(wr_way), .wr_index(wr_index), .wr_line(wr_line),
        .wr_strb(wr_strb), .wr_tag_en(wr_tag_en), .wr_tag(wr_tag),
        .wr_dv_en(wr_dv_en), .wr_valid(wr_valid), .wr_dirty(wr_dirty),
        .inv_req(inv_req), .inv_done(inv_done)
    );

    typedef struct {
        bit                hit;
        int                hit_way;
        logic [LINE_W-1:0] hit_line;
        int                vic_way;
        logic [TAG_W-1:0]  vic_tag;
        logic [LINE_W-1:0] vic_line;
        bit                vic_valid;
        bit                vic_dirty;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;

    logic [TAG_W-1:0]  m_tag   [WAYS][SETS];
    logic [LINE_W-1:0] m_data  [WAYS][SETS];
    bit                m_valid [WAYS][SETS];
    bit                m_dirty [WAYS][SETS];
    int                m_lru   [SETS];

    int total = 0;
    int bad   = 0;

    localparam logic [LINE_W-1:0] LINE_A  = 128'h44444444_33333333_22222222_33331111;
    localparam logic [LINE_W-1:0] LINE_ST = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF;
    localparam logic [LINE_W-1:0] STORED  = 128'h44444444_33333333_22222222_3333BEEF;
    localparam logic [LINE_W-1:0] LINE_B  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [LINE_W-1:0] LINE_C  = 128'hCCCC_0000_CCCC_0001_CCCC_0002_CCCC_0003;
    localparam logic [LINE_W-1:0] LINE_D  = 128'hDDDD_1111_DDDD_2222_DDDD_3333_DDDD_4444;
    localparam logic [LINE_W-1:0] LINE_E  = 128'hE0E0_E0E0_E1E1_E1E1_E2E2_E2E2_E3E3_E3E3;
    localparam logic [LINE_W-1:0] LINE_F  = 128'hF0F0_F0F0_F1F1_F1F1_F2F2_F2F2_F3F3_F3F3;
    localparam logic [LINE_W-1:0] LINE_G  = 128'h9999_8888_7777_6666_5555_4444_3333_2222;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
            end
        end
    endfunction

    // Victim: first invalid way, else the least recently touched way of the pair.
    function automatic void model_lookup(input int idx, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.hit = 1'b0; e.hit_way = 0; e.hit_line = '0; e.vic_way = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (!e.hit && m_valid[w][idx] && m_tag[w][idx] == tag) begin
                e.hit = 1'b1; e.hit_way = w; e.hit_line = m_data[w][idx];
            end
            if (e.vic_way < 0 && !m_valid[w][idx]) e.vic_way = w;
        end
        if (e.vic_way < 0) e.vic_way = m_lru[idx];
        e.vic_tag   = m_tag[e.vic_way][idx];
        e.vic_line  = m_data[e.vic_way][idx];
        e.vic_valid = m_valid[e.vic_way][idx];
        e.vic_dirty = m_dirty[e.vic_way][idx];
        exp_q.push_back(e);
        if (e.hit) m_lru[idx] = 1 - e.hit_way;
    endfunction

    task automatic drive_rd(input int idx, input logic [TAG_W-1:0] tag);
        rd_en = 1'b1; rd_index = INDEX_W'(idx); rd_tag = tag;
        model_lookup(idx, tag);
    endtask

    task automatic drive_wr(input int way, input int idx, input logic [LINE_W-1:0] line,
                            input logic [BYTES-1:0] strb, input bit tag_en, input logic [TAG_W-1:0] tag,
                            input bit dv_en, input bit v, input bit d);
        wr_en = 1'b1; wr_way = 1'(way); wr_index = INDEX_W'(idx); wr_line = line; wr_strb = strb;
        wr_tag_en = tag_en; wr_tag = tag; wr_dv_en = dv_en; wr_valid = v; wr_dirty = d;
        for (int b = 0; b < BYTES; b++)
            if (strb[b]) m_data[way][idx][b*8 +: 8] = line[b*8 +: 8];
        if (tag_en) begin
            m_tag[way][idx] = tag;
            m_lru[idx] = 1 - way;
        end
        if (dv_en) begin
            m_valid[way][idx] = v;
            m_dirty[way][idx] = d;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; wr_tag_en = 1'b0; wr_dv_en = 1'b0; inv_req = 1'b0;
    endtask

    task automatic realign();
        @(posedge clk); #1;
    endtask

    // Counts not-ready cycles of a clear sweep; optionally pokes inv_req/rd_en mid-sweep.
    task automatic sweep(input bit poke, input string nm);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ready) break;
            cnt++;
            if (poke && i == 5) begin inv_req = 1'b1; rd_en = 1'b1; rd_index = 7'd10; end
            if (poke && i == 6) begin inv_req = 1'b0; rd_en = 1'b0; end
        end
        chk({nm, "_ready_low_cycles"}, LINE_W'(cnt), LINE_W'(SETS));
        chk({nm, "_inv_done_pulse"}, LINE_W'(inv_done), 1);
        @(negedge clk);
        chk({nm, "_inv_done_clear"}, LINE_W'(inv_done), 0);
        chk({nm, "_ready_stays"}, LINE_W'(ready), 1);
        realign();
        model_clear();
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
            end else begin
                e_cur = exp_q.pop_front();
                chk("rsp_hit", LINE_W'(hit), LINE_W'(e_cur.hit));
                if (e_cur.hit) begin
                    chk("rsp_hit_way", LINE_W'(hit_way), LINE_W'(e_cur.hit_way));
                    chk("rsp_hit_line", hit_line, e_cur.hit_line);
                end
                chk("rsp_vic_way", LINE_W'(vic_way), LINE_W'(e_cur.vic_way));
                chk("rsp_vic_valid", LINE_W'(vic_valid), LINE_W'(e_cur.vic_valid));
                chk("rsp_vic_dirty", LINE_W'(vic_dirty), LINE_W'(e_cur.vic_dirty));
                if (e_cur.vic_valid) begin
                    chk("rsp_vic_tag", LINE_W'(vic_tag), LINE_W'(e_cur.vic_tag));
                    chk("rsp_vic_line", vic_line, e_cur.vic_line);
                end
            end
        end else begin
            chk("idle_hit_low", LINE_W'(hit), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; rd_en = 1'b0; rd_index = '0; rd_tag = '0;
        wr_en = 1'b0; wr_way = '0; wr_index = '0; wr_line = '0; wr_strb = '0;
        wr_tag_en = 1'b0; wr_tag = '0; wr_dv_en = 1'b0; wr_valid = 1'b0; wr_dirty = 1'b0;
        inv_req = 1'b0;
        model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin m_tag[w][s] = '0; m_data[w][s] = '0; end

        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_ready", LINE_W'(ready), 0);
        chk("reset_rsp_valid", LINE_W'(rsp_valid), 0);
        chk("reset_inv_done", LINE_W'(inv_done), 0);
        chk("reset_vic_way", LINE_W'(vic_way), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        sweep(1'b0, "reset");

        drive_rd(0, 20'h12345); tick();
        @(negedge clk);
        chk("post_reset_rsp_valid", LINE_W'(rsp_valid), 1);
        chk("post_reset_hit", LINE_W'(hit), 0);
        chk("post_reset_vic_valid", LINE_W'(vic_valid), 0);
        chk("post_reset_vic_way", LINE_W'(vic_way), 0);
        realign();

        drive_wr(1, 5, LINE_A, 16'hFFFF, 1'b1, 20'hABCDE, 1'b1, 1'b1, 1'b0); tick();
        drive_rd(5, 20'hABCDE); tick();
        @(negedge clk);
        chk("refill_hit", LINE_W'(hit), 1);
        chk("refill_hit_way", LINE_W'(hit_way), 1);
        chk("refill_hit_line", hit_line, LINE_A);
        realign();

        drive_wr(1, 5, LINE_ST, 16'h0003, 1'b0, '0, 1'b1, 1'b1, 1'b1); tick();
        drive_rd(5, 20'hABCDE); tick();
        @(negedge clk);
        chk("strobe_line", hit_line, STORED);
        realign();
        drive_wr(0, 5, LINE_B, 16'hFFFF, 1'b1, 20'h22222, 1'b1, 1'b1, 1'b0); tick();
        drive_rd(5, 20'h55555); tick();
        @(negedge clk);
        chk("dirty_vic_hit", LINE_W'(hit), 0);
        chk("dirty_vic_way", LINE_W'(vic_way), 1);
        chk("dirty_vic_dirty", LINE_W'(vic_dirty), 1);
        chk("dirty_vic_tag", LINE_W'(vic_tag), LINE_W'(20'hABCDE));
        chk("dirty_vic_line", vic_line, STORED);
        realign();

        drive_wr(0, 20, LINE_C, 16'hFFFF, 1'b1, 20'h00AAA, 1'b1, 1'b1, 1'b0); tick();
        drive_rd(20, 20'h00AAA);
        drive_wr(0, 20, LINE_D, 16'hFFFF, 1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
        drive_rd(20, 20'h00AAA);
        @(negedge clk);
        chk("read_first_old", hit_line, LINE_C);
        tick();
        @(negedge clk);
        chk("read_first_new", hit_line, LINE_D);
        realign();

        drive_wr(0, 3, LINE_E, 16'hFFFF, 1'b1, 20'h00003, 1'b1, 1'b1, 1'b0); tick();
        drive_wr(1, 3, LINE_F, 16'hFFFF, 1'b1, 20'h10003, 1'b1, 1'b1, 1'b0); tick();
        drive_rd(3, 20'h00003); tick(); tick();
        drive_rd(3, 20'h77777); tick();
        @(negedge clk);
        chk("plru_after_hit0", LINE_W'(vic_way), 1);
        chk("plru_vic_valid", LINE_W'(vic_valid), 1);
        realign();
        drive_rd(3, 20'h10003); tick(); tick();
        drive_rd(3, 20'h77777); tick();
        @(negedge clk);
        chk("plru_after_hit1", LINE_W'(vic_way), 0);
        realign();

        drive_wr(0, 10, LINE_G, 16'hFFFF, 1'b1, 20'h0A0A0, 1'b1, 1'b1, 1'b1); tick();
        drive_rd(10, 20'h0A0A0); tick();
        @(negedge clk);
        chk("pre_inv_hit", LINE_W'(hit), 1);
        realign();
        inv_req = 1'b1; tick();
        sweep(1'b1, "inv");
        drive_rd(10, 20'h0A0A0); tick();
        @(negedge clk);
        chk("post_inv_hit", LINE_W'(hit), 0);
        chk("post_inv_vic_valid", LINE_W'(vic_valid), 0);
        chk("post_inv_vic_dirty", LINE_W'(vic_dirty), 0);
        realign();

        tick(); tick();
        chk("pending_rsp", LINE_W'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
